// File: rtl/seq_mult_param.sv
// Radix-2 shift-add multiplier. Latency WIDTH+1 (WIDTH+2 with FIX). start is ignored while busy. Nothing is queued.
// Optional macro SEQ_MULT_SIGNED_EN adds the is_signed port and a one-cycle sign-fixup FIX state.

module seq_mult_param #(
  parameter int WIDTH = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               carry_q;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] product_q;

  logic               load_ops;
  logic               step;
  logic               load_prod;
  logic               last_iter;

  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic [2*WIDTH-1:0] prod_next;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q;
  logic neg_in;

  // Signed operands run through the unsigned core as magnitudes; 2^(W-1) still fits in W bits.
  always_comb begin
    neg_in    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    mcand_in  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mplier_in = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  end
`else
  always_comb begin
    mcand_in  = op_a;
    mplier_in = op_b;
  end
`endif

  // One partial product per cycle: conditional add into the high half, then shift the whole word right.
  always_comb begin
    addend  = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum     = {carry_q, acc_q[2*WIDTH-1:WIDTH]} + addend;
    shifted = {sum, acc_q[WIDTH-1:0]} >> 1;
  end

`ifdef SEQ_MULT_SIGNED_EN
  always_comb begin
    prod_next = neg_q ? -acc_q : acc_q;
  end
`else
  always_comb begin
    prod_next = shifted[2*WIDTH-1:0];
  end
`endif

  assign last_iter = (count_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    load_ops  = 1'b0;
    step      = 1'b0;
    load_prod = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_ops = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_iter) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_d = S_FIX;
`else
          load_prod = 1'b1;
          state_d   = S_DONE;
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      S_FIX: begin
        busy      = 1'b1;
        load_prod = 1'b1;
        state_d   = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        // A start seen during the done pulse launches the next operation with no idle bubble.
        if (start) begin
          load_ops = 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load_ops) begin
        mcand_q <= mcand_in;
        acc_q   <= {{WIDTH{1'b0}}, mplier_in};
        carry_q <= 1'b0;
        count_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_q   <= neg_in;
`endif
      end else if (step) begin
        acc_q   <= shifted[2*WIDTH-1:0];
        carry_q <= shifted[2*WIDTH];
        count_q <= count_q + 1'b1;
      end
      if (load_prod) begin
        product_q <= prod_next;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: WIDTH=4 and WIDTH=8 instances driven with directed and random operations.
// Expected products come from plain integer multiplication. Busy and done timing comes from the fixed latency.

module tb_seq_mult_param;

`ifdef SEQ_MULT_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT4 = 4 + 1 + EXTRA;
  localparam int LAT8 = 8 + 1 + EXTRA;

  logic        clk;
  logic        rst4, start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;
  logic        rst8, start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
`ifdef SEQ_MULT_SIGNED_EN
  logic        sgn4, sgn8;
`endif

  int          n_checks;
  int          n_fail;
  logic [7:0]  prev4;
  logic [15:0] prev8;

  seq_mult_param #(.WIDTH(4)) u4 (
    .sys_clk(clk), .sys_rst(rst4), .start(start4),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed(sgn4),
`endif
    .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mult_param #(.WIDTH(8)) u8 (
    .sys_clk(clk), .sys_rst(rst8), .start(start8),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed(sgn8),
`endif
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact product of the operands, two's complement when s=1, kept to 16 bits.
  function automatic logic [15:0] ref_mult8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb;
    sa = (s && a[7]) ? int'(a) - 256 : int'(a);
    sb = (s && b[7]) ? int'(b) - 256 : int'(b);
    return 16'(sa * sb);
  endfunction

  task automatic test_reset;
    rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b1; start8 = 1'b1;
    a4 = 4'd15; b4 = 4'd15; a8 = 8'd200; b8 = 8'd3;
    tick(); tick();
    n_checks++;
    if ({busy4, done4, prod4} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_w4: got busy=%b done=%b product=%h, want 0 0 00", busy4, done4, prod4);
    end
    n_checks++;
    if ({busy8, done8, prod8} !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_w8: got busy=%b done=%b product=%h, want 0 0 0000", busy8, done8, prod8);
    end
    rst4 = 1'b0; rst8 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    tick();
    n_checks++;
    if ({busy4, done4, busy8, done8} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release: got b4=%b d4=%b b8=%b d8=%b, want all 0", busy4, done4, busy8, done8);
    end
    prev4 = 8'h00;
    prev8 = 16'h0000;
  endtask

  task automatic test_max4;
    logic [9:0] exp_v;
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    for (int cyc = 1; cyc <= LAT4 + 3; cyc++) begin
      tick();
      if (cyc == 1) begin
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      end
      exp_v = {1'(cyc < LAT4), 1'(cyc == LAT4), (cyc < LAT4) ? prev4 : 8'hE1};
      n_checks++;
      if ({busy4, done4, prod4} !== exp_v) begin
        n_fail++;
        $display("FAIL max4 cyc%0d: got %b_%b_%h want %b_%b_%h", cyc, busy4, done4, prod4,
                 exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
    prev4 = 8'hE1;
  endtask

  task automatic test_vectors_w8;
    logic [7:0]  va [3] = '{8'd0, 8'd255, 8'd1};
    logic [7:0]  vb [3] = '{8'd255, 8'd255, 8'd200};
    logic [15:0] exp_p;
    logic [17:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      exp_p = ref_mult8(va[i], vb[i], 1'b0);
      a8 = va[i]; b8 = vb[i]; start8 = 1'b1;
      for (int cyc = 1; cyc <= LAT8 + 1; cyc++) begin
        tick();
        if (cyc == 1) start8 = 1'b0;
        exp_v = {1'(cyc < LAT8), 1'(cyc == LAT8), (cyc < LAT8) ? prev8 : exp_p};
        n_checks++;
        if ({busy8, done8, prod8} !== exp_v) begin
          n_fail++;
          $display("FAIL vec8[%0d] cyc%0d: got %b_%b_%h want %b_%b_%h", i, cyc, busy8, done8, prod8,
                   exp_v[17], exp_v[16], exp_v[15:0]);
        end
      end
      prev8 = exp_p;
    end
  endtask

  task automatic test_ignore_busy;
    logic [9:0] exp_v;
    a4 = 4'd7; b4 = 4'd3; start4 = 1'b1;
    for (int cyc = 1; cyc <= LAT4 + 4; cyc++) begin
      tick();
      if (cyc == 1) start4 = 1'b0;
      if (cyc == 2) begin
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd2;
      end
      if (cyc == 4) start4 = 1'b0;
      exp_v = {1'(cyc < LAT4), 1'(cyc == LAT4), (cyc < LAT4) ? prev4 : 8'd21};
      n_checks++;
      if ({busy4, done4, prod4} !== exp_v) begin
        n_fail++;
        $display("FAIL ignore_busy cyc%0d: got %b_%b_%h want %b_%b_%h", cyc, busy4, done4, prod4,
                 exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
    prev4 = 8'd21;
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_v;
    logic [7:0] exp_p;
    logic       exp_busy;
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    for (int cyc = 1; cyc <= 2 * LAT4 + 2; cyc++) begin
      tick();
      if (cyc == LAT4) begin
        a4 = 4'd6; b4 = 4'd6;
      end
      if (cyc == LAT4 + 1) start4 = 1'b0;
      exp_busy = (cyc < LAT4) || (cyc > LAT4 && cyc < 2 * LAT4);
      exp_p    = (cyc < LAT4) ? prev4 : (cyc < 2 * LAT4) ? 8'd15 : 8'd36;
      exp_v    = {exp_busy, 1'(cyc == LAT4 || cyc == 2 * LAT4), exp_p};
      n_checks++;
      if ({busy4, done4, prod4} !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got %b_%b_%h want %b_%b_%h", cyc, busy4, done4, prod4,
                 exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
    prev4 = 8'd36;
  endtask

  task automatic test_reset_mid;
    logic [17:0] exp_v;
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      if (cyc == 1) start8 = 1'b0;
      n_checks++;
      if ({busy8, done8, prod8} !== {2'b10, prev8}) begin
        n_fail++;
        $display("FAIL reset_mid run cyc%0d: got %b_%b_%h want 1_0_%h", cyc, busy8, done8, prod8, prev8);
      end
    end
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    for (int cyc = 5; cyc <= 5 + LAT8 + 2; cyc++) begin
      n_checks++;
      if ({busy8, done8, prod8} !== 18'b0) begin
        n_fail++;
        $display("FAIL reset_mid after cyc%0d: got %b_%b_%h want 0_0_0000", cyc, busy8, done8, prod8);
      end
      tick();
    end
    prev8 = 16'h0000;
    a8 = 8'd10; b8 = 8'd10; start8 = 1'b1;
    for (int cyc = 1; cyc <= LAT8 + 1; cyc++) begin
      tick();
      if (cyc == 1) start8 = 1'b0;
      exp_v = {1'(cyc < LAT8), 1'(cyc == LAT8), (cyc < LAT8) ? prev8 : 16'd100};
      n_checks++;
      if ({busy8, done8, prod8} !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid fresh cyc%0d: got %b_%b_%h want %b_%b_%h", cyc, busy8, done8, prod8,
                 exp_v[17], exp_v[16], exp_v[15:0]);
      end
    end
    prev8 = 16'd100;
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed;
    logic [3:0] va [4] = '{4'hD, 4'h8, 4'hD, 4'h8};
    logic [3:0] vb [4] = '{4'h5, 4'h8, 4'h5, 4'h7};
    logic       vs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] vp [4] = '{8'hF1, 8'h40, 8'h41, 8'hC8};
    logic [9:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      a4 = va[i]; b4 = vb[i]; sgn4 = vs[i]; start4 = 1'b1;
      for (int cyc = 1; cyc <= LAT4 + 1; cyc++) begin
        tick();
        if (cyc == 1) begin
          start4 = 1'b0; sgn4 = ~vs[i]; a4 = 4'($urandom); b4 = 4'($urandom);
        end
        exp_v = {1'(cyc < LAT4), 1'(cyc == LAT4), (cyc < LAT4) ? prev4 : vp[i]};
        n_checks++;
        if ({busy4, done4, prod4} !== exp_v) begin
          n_fail++;
          $display("FAIL signed[%0d] cyc%0d: got %b_%b_%h want %b_%b_%h", i, cyc, busy4, done4, prod4,
                   exp_v[9], exp_v[8], exp_v[7:0]);
        end
      end
      prev4 = vp[i];
    end
  endtask
`endif

  task automatic test_random;
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] exp_p;
    logic [17:0] exp_v;
    int          gap;
    for (int op = 0; op < 30; op++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (op % 7 == 0) a = 8'h80;
      if (op % 5 == 0) b = 8'hFF;
`ifdef SEQ_MULT_SIGNED_EN
      s = 1'($urandom);
      sgn8 = s;
`else
      s = 1'b0;
`endif
      exp_p = ref_mult8(a, b, s);
      a8 = a; b8 = b; start8 = 1'b1;
      for (int cyc = 1; cyc <= LAT8; cyc++) begin
        tick();
        if (cyc < LAT8) begin
          start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
          sgn8 = 1'($urandom);
`endif
        end else begin
          start8 = 1'b0;
        end
        exp_v = {1'(cyc < LAT8), 1'(cyc == LAT8), (cyc < LAT8) ? prev8 : exp_p};
        n_checks++;
        if ({busy8, done8, prod8} !== exp_v) begin
          n_fail++;
          $display("FAIL random op%0d (%h*%h s=%b) cyc%0d: got %b_%b_%h want %b_%b_%h", op, a, b, s, cyc,
                   busy8, done8, prod8, exp_v[17], exp_v[16], exp_v[15:0]);
        end
      end
      prev8 = exp_p;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        n_checks++;
        if ({busy8, done8, prod8} !== {2'b00, prev8}) begin
          n_fail++;
          $display("FAIL random idle op%0d: got %b_%b_%h want 0_0_%h", op, busy8, done8, prod8, prev8);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev4    = 8'h00;
    prev8    = 16'h0000;
    rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
`ifdef SEQ_MULT_SIGNED_EN
    sgn4 = 1'b0; sgn8 = 1'b0;
`endif
    test_reset();
    test_max4();
    test_vectors_w8();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
    sgn4 = 1'b0;
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
